// File: rtl/booth_r4_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, signed or unsigned operands.
// Extended operands make both modes share one datapath and the same fixed latency.
module booth_r4_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int E  = WIDTH + 2;
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [E:0] ONE = 1;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_r4_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [E-1:0]  m_ext;
    logic [E-1:0]  p_hi;
    logic [E-1:0]  p_lo;
    logic          q;

    logic [E:0]    m_x;
    logic [E:0]    addend;
    logic [E:0]    sum;
    logic          sx_a;
    logic          sx_b;

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);
    assign sx_a = signed_mode & multiplicand[WIDTH-1];
    assign sx_b = signed_mode & multiplier[WIDTH-1];
    assign m_x  = {m_ext[E-1], m_ext};

    // One extra bit of headroom keeps P_hi +/- 2M from overflowing.
    always_comb begin
        addend = '0;
        case ({p_lo[1:0], q})
            3'b001, 3'b010: addend = m_x;
            3'b011:         addend = {m_x[E-1:0], 1'b0};
            3'b100:         addend = ~{m_x[E-1:0], 1'b0} + ONE;
            3'b101, 3'b110: addend = ~m_x + ONE;
            default:        addend = '0;
        endcase
        sum = {p_hi[E-1], p_hi} + addend;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            m_ext   <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            q       <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        m_ext <= {sx_a, sx_a, multiplicand};
                        p_hi  <= '0;
                        p_lo  <= {sx_b, sx_b, multiplier};
                        q     <= 1'b0;
                        cnt   <= CW'(N);
                        state <= S_CALC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (cnt == '0) begin
                        // All N digits retired; low 2*WIDTH bits hold the exact product.
                        product <= {p_hi[WIDTH-3:0], p_lo};
                        state   <= S_DONE;
                    end else begin
                        p_hi <= {sum[E], sum[E:2]};
                        p_lo <= {sum[1:0], p_lo[E-1:2]};
                        q    <= p_lo[1];
                        cnt  <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_r4_mult.sv
// Self-checking bench for booth_r4_mult: directed corners on an 8-bit unit, random sweep on a 16-bit unit.
module tb_booth_r4_mult;
    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] prod16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_r4_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    booth_r4_mult #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16), .busy(busy16), .done(done16), .product(prod16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer multiplication, truncated to 2*W bits.
    function automatic logic [15:0] ref8(input bit sm, input logic [7:0] a, input logic [7:0] b);
        longint x, y;
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    function automatic logic [31:0] ref16(input bit sm, input logic [15:0] a, input logic [15:0] b);
        longint x, y;
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        return 32'(x * y);
    endfunction

    task automatic op8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat, output int bcnt);
        @(negedge clk);
        sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat  = 0;
        bcnt = busy8 ? 1 : 0;
        while (!done8 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (busy8) bcnt++;
        end
        p = prod8;
    endtask

    task automatic op16(input bit sm, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] p, output int lat);
        @(negedge clk);
        sm16 = sm; a16 = a; b16 = b; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        p = prod16;
    endtask

    // Full directed op on the 8-bit unit: product, latency, busy length, single-cycle done.
    task automatic dir8(input string tag, input bit sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
        logic [15:0] p;
        int lat, bcnt;
        op8(sm, a, b, p, lat, bcnt);
        chk({tag, "_prod"}, 64'(p), 64'(exp));
        chk({tag, "_lat"}, 64'(lat), 64'd6);
        chk({tag, "_busy"}, 64'(bcnt), 64'd6);
        chk({tag, "_done_busy"}, 64'(busy8), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done8), 64'd0);
    endtask

    initial begin
        logic [15:0] p8;
        logic [31:0] p32;
        int lat, bcnt, t1, t2, seen;
        logic [15:0] pa, pb;
        bit sm;
        logic [7:0] ra, rb;
        logic [15:0] wa, wb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_prod", 64'(prod8), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        dir8("t1_s11xm10", 1'b1, 8'd11, 8'hF6, 16'hFF92);
        dir8("t2_uff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        dir8("t2_sff", 1'b1, 8'hFF, 8'hFF, 16'h0001);
        dir8("t3_s80x7f", 1'b1, 8'h80, 8'h7F, 16'hC080);
        dir8("t3_s80x80", 1'b1, 8'h80, 8'h80, 16'h4000);

        // Back-to-back with start held; operands change mid-CALC.
        @(negedge clk);
        sm8 = 1'b0; a8 = 8'd14; b8 = 8'd13; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd24; b8 = 8'd34;
        t1 = -1; t2 = -1; seen = 0; pa = '0; pb = '0;
        for (int t = 1; t <= 40 && seen < 2; t++) begin
            @(posedge clk); #1;
            if (t == t1 + 2 && seen == 1) begin
                a8 = 8'd99; b8 = 8'd99;
            end
            if (done8) begin
                if (seen == 0) begin
                    t1 = t; pa = prod8;
                end else begin
                    t2 = t; pb = prod8;
                    start8 = 1'b0;
                end
                seen++;
            end
        end
        start8 = 1'b0;
        chk("t4_first_prod", 64'(pa), 64'h00B6);
        chk("t4_second_prod", 64'(pb), 64'h0330);
        chk("t4_first_lat", 64'(t1), 64'd6);
        chk("t4_spacing", 64'(t2 - t1), 64'd7);
        @(posedge clk); #1;
        chk("t4_idle_after", 64'(busy8 | done8), 64'd0);

        // Reset during the third CALC cycle aborts the op.
        @(negedge clk);
        sm8 = 1'b0; a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_busy", 64'(busy8), 64'd0);
        chk("t5_rst_done", 64'(done8), 64'd0);
        chk("t5_rst_prod", 64'(prod8), 64'd0);
        reset = 1'b0;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen++;
        end
        chk("t5_no_done", 64'(seen), 64'd0);
        dir8("t5_after", 1'b0, 8'd76, 8'd98, 16'h1D18);

        // Random sweep on the 8-bit unit.
        for (int i = 0; i < 200; i++) begin
            sm = 1'($urandom_range(0, 1));
            ra = 8'($urandom); rb = 8'($urandom);
            op8(sm, ra, rb, p8, lat, bcnt);
            chk("rnd8_prod", 64'(p8), 64'(ref8(sm, ra, rb)));
            chk("rnd8_lat", 64'(lat), 64'd6);
        end

        // Random sweep on the 16-bit unit, both modes.
        for (int i = 0; i < 1000; i++) begin
            sm = 1'(i & 1);
            wa = 16'($urandom); wb = 16'($urandom);
            if (i < 8) begin
                wa = (i & 2) != 0 ? 16'h8000 : 16'hFFFF;
                wb = (i & 4) != 0 ? 16'h8000 : 16'h7FFF;
            end
            op16(sm, wa, wb, p32, lat);
            chk("rnd16_prod", 64'(p32), 64'(ref16(sm, wa, wb)));
            chk("rnd16_lat", 64'(lat), 64'd10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
